// File: rtl/ber_monitor_pkg.sv
// Shared types and constants for the BER monitor: FSM state encoding,
// received word width, popcount width and lock-loss counter width.
package ber_monitor_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned POP_W  = 6;
  localparam int unsigned LOCK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ALIGN = 2'd1,
    ST_MEASURE    = 2'd2,
    ST_DONE       = 2'd3
  } ber_state_e;

  // Lock-loss events stick at 255 rather than wrapping back to a small count.
  function automatic logic [LOCK_W-1:0] lock_sat_inc(input logic [LOCK_W-1:0] v);
    return (v == {LOCK_W{1'b1}}) ? v : v + LOCK_W'(1);
  endfunction

endpackage

// File: rtl/ber_monitor_popcount32.sv
// Combinational population count of one 32-bit error mask (result 0..32).
module popcount32
  import ber_monitor_pkg::*;
(
  input  logic [WORD_W-1:0] bits_i,
  output logic [POP_W-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      count_o = count_o + POP_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: counts aligned words, errored words, error bits and
// lock losses over a 2^WINDOW_LOG2 word window. Bit counting needs BER_BIT_ERR_COUNT_EN.
module ber_monitor
  import ber_monitor_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 20,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              aligned,
  input  logic              errorFlag,
  input  logic [WORD_W-1:0] errorBits,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wordCount,
  output logic [CNT_W-1:0]  errWordCount,
  output logic [CNT_W-1:0]  errBitCount,
  output logic [LOCK_W-1:0] lockLoss,
  output ber_state_e        state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] WINDOW_WORDS = CNT_ONE << WINDOW_LOG2;

  ber_state_e        state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_word_cnt_q, err_word_cnt_d;
  logic [LOCK_W-1:0] lock_loss_q, lock_loss_d;
  logic              clear_all;
  logic              count_word;

  // Next state and counter updates; only a MEASURE edge with aligned=1 counts a word.
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    err_word_cnt_d = err_word_cnt_q;
    lock_loss_d    = lock_loss_q;
    clear_all      = 1'b0;
    count_word     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_all      = 1'b1;
          word_cnt_d     = '0;
          err_word_cnt_d = '0;
          lock_loss_d    = '0;
          state_d        = ST_WAIT_ALIGN;
        end
      end
      ST_WAIT_ALIGN: begin
        if (aligned) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (aligned) begin
          count_word = 1'b1;
          word_cnt_d = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + CNT_ONE;
          if (errorFlag && (err_word_cnt_q != CNT_MAX)) begin
            err_word_cnt_d = err_word_cnt_q + CNT_ONE;
          end
          if (word_cnt_d == WINDOW_WORDS) state_d = ST_DONE;
        end else begin
          lock_loss_d = lock_sat_inc(lock_loss_q);
          state_d     = ST_WAIT_ALIGN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      word_cnt_q     <= '0;
      err_word_cnt_q <= '0;
      lock_loss_q    <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      err_word_cnt_q <= err_word_cnt_d;
      lock_loss_q    <= lock_loss_d;
    end
  end

`ifdef BER_BIT_ERR_COUNT_EN
  // Sum is one bit wider than either operand so an overflow can be detected and clamped.
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [POP_W-1:0] pop_cnt;
  logic [SUM_W-1:0] bit_sum;
  logic [CNT_W-1:0] err_bit_cnt_q, err_bit_cnt_d;

  popcount32 u_popcount (
    .bits_i  (errorBits),
    .count_o (pop_cnt)
  );

  assign bit_sum = SUM_W'(err_bit_cnt_q) + SUM_W'(pop_cnt);

  always_comb begin
    err_bit_cnt_d = err_bit_cnt_q;
    if (clear_all) begin
      err_bit_cnt_d = '0;
    end else if (count_word) begin
      err_bit_cnt_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_bit_cnt_q <= '0;
    end else begin
      err_bit_cnt_q <= err_bit_cnt_d;
    end
  end

  assign errBitCount = err_bit_cnt_q;
`else
  logic unused_bit_path;
  assign unused_bit_path = ^{errorBits, clear_all, count_word};
  assign errBitCount     = '0;
`endif

  assign busy         = (state_q == ST_WAIT_ALIGN) || (state_q == ST_MEASURE);
  assign done         = (state_q == ST_DONE);
  assign wordCount    = word_cnt_q;
  assign errWordCount = err_word_cnt_q;
  assign lockLoss     = lock_loss_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ber_monitor.sv
// Bench for ber_monitor: a 32-bit counter instance and a 5-bit saturating
// instance share stimulus; both are checked against a behavioural model each cycle.
module tb_ber_monitor;
  import ber_monitor_pkg::*;

`ifdef BER_BIT_ERR_COUNT_EN
  localparam bit BIT_EN = 1'b1;
`else
  localparam bit BIT_EN = 1'b0;
`endif
  localparam int WL     = 4;
  localparam int WINDOW = 1 << WL;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk;
  logic        reset;
  logic        start, aligned, errorFlag;
  logic [31:0] errorBits;

  logic        busy, done;
  logic [31:0] wordCount, errWordCount, errBitCount;
  logic [7:0]  lockLoss;
  ber_state_e  state_o;

  logic        s_busy, s_done;
  logic [4:0]  s_wordCount, s_errWordCount, s_errBitCount;
  logic [7:0]  s_lockLoss;
  ber_state_e  s_state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ber_monitor #(.WINDOW_LOG2(WL), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .aligned(aligned),
    .errorFlag(errorFlag), .errorBits(errorBits), .busy(busy), .done(done),
    .wordCount(wordCount), .errWordCount(errWordCount), .errBitCount(errBitCount),
    .lockLoss(lockLoss), .state_o(state_o)
  );

  ber_monitor #(.WINDOW_LOG2(WL), .CNT_W(5)) u_sat (
    .clk(clk), .reset(reset), .start(start), .aligned(aligned),
    .errorFlag(errorFlag), .errorBits(errorBits), .busy(s_busy), .done(s_done),
    .wordCount(s_wordCount), .errWordCount(s_errWordCount), .errBitCount(s_errBitCount),
    .lockLoss(s_lockLoss), .state_o(s_state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // [0] = 32-bit instance, [1] = 5-bit instance.
  bit     m_active[2];   // between an accepted start and window completion
  bit     m_locked[2];   // aligned has been seen since start / last lock loss
  bit     m_done[2];
  longint m_words[2], m_errw[2], m_errb[2], m_lock[2];
  longint m_max[2] = '{64'hFFFF_FFFF, 31};

  logic [31:0] exp_q[$];   // expected errWordCount for every completed window
  bit          prev_done;

  function automatic longint clamp(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_locked[k] = 0; m_done[k] = 0;
      m_words[k] = 0; m_errw[k] = 0; m_errb[k] = 0; m_lock[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit s, input bit a, input bit f, input logic [31:0] b);
    if (!m_active[k]) begin
      if (s) begin
        m_active[k] = 1; m_locked[k] = 0; m_done[k] = 0;
        m_words[k] = 0; m_errw[k] = 0; m_errb[k] = 0; m_lock[k] = 0;
      end
    end else if (!m_locked[k]) begin
      if (a) m_locked[k] = 1;
    end else if (a) begin
      m_words[k] = clamp(m_words[k] + 1, m_max[k]);
      m_errw[k]  = clamp(m_errw[k] + longint'(f), m_max[k]);
      if (BIT_EN) m_errb[k] = clamp(m_errb[k] + longint'($countones(b)), m_max[k]);
      if (m_words[k] == longint'(WINDOW)) begin
        m_active[k] = 0; m_done[k] = 1;
        if (k == 0) exp_q.push_back(m_errw[0][31:0]);
      end
    end else begin
      m_lock[k]   = clamp(m_lock[k] + 1, 255);
      m_locked[k] = 0;
    end
  endtask

  function automatic ber_state_e m_state(input int k);
    if (m_active[k]) return m_locked[k] ? ST_MEASURE : ST_WAIT_ALIGN;
    return m_done[k] ? ST_DONE : ST_IDLE;
  endfunction

  task automatic cmp_model();
    chk("busy",       64'(busy),         64'(m_active[0]));
    chk("done",       64'(done),         64'(m_done[0]));
    chk("wordCount",  64'(wordCount),    64'(m_words[0]));
    chk("errWord",    64'(errWordCount), 64'(m_errw[0]));
    chk("errBit",     64'(errBitCount),  64'(m_errb[0]));
    chk("lockLoss",   64'(lockLoss),     64'(m_lock[0]));
    chk("state",      64'(state_o),      64'(m_state(0)));
    chk("s_busy",     64'(s_busy),       64'(m_active[1]));
    chk("s_done",     64'(s_done),       64'(m_done[1]));
    chk("s_wordCount",64'(s_wordCount),  64'(m_words[1]));
    chk("s_errWord",  64'(s_errWordCount),64'(m_errw[1]));
    chk("s_errBit",   64'(s_errBitCount),64'(m_errb[1]));
    chk("s_lockLoss", 64'(s_lockLoss),   64'(m_lock[1]));
    chk("s_state",    64'(s_state_o),    64'(m_state(1)));
    // Scoreboard: each rising done consumes one completed-window result.
    if (done && !prev_done) begin
      chk("window_queued", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("window_errWord", 64'(errWordCount), 64'(exp_q.pop_front()));
    end
    prev_done = done;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit s, input bit a, input bit f, input logic [31:0] b);
    start = s; aligned = a; errorFlag = f; errorBits = b;
    @(posedge clk);
    if (!reset) model_reset();
    else for (int k = 0; k < 2; k++) model_edge(k, s, a, f, b);
    #1;
    cmp_model();
  endtask

  task automatic words(input int n, input bit f, input logic [31:0] b);
    for (int i = 0; i < n; i++) step(0, 1, f, b);
  endtask

  // Assert reset between edges, check outputs before the next edge, release after two edges.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_words", 64'(wordCount), 64'(0));
    chk("rst_errw", 64'(errWordCount), 64'(0));
    chk("rst_errb", 64'(errBitCount), 64'(0));
    chk("rst_lock", 64'(lockLoss), 64'(0));
    chk("rst_state", 64'(state_o), 64'(ST_IDLE));
    cmp_model();
    step(1, 1, 1, '1);
    step(0, 1, 1, '1);
    reset = 1'b1;
  endtask

  task automatic random_phase(input int n);
    bit          rs, ra, rf;
    logic [31:0] rb;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        rs = ($urandom_range(0, 19) == 0);
        ra = ($urandom_range(0, 7) != 0);
        rf = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
          0:       rb = '0;
          1:       rb = 32'h1 << $urandom_range(0, 31);
          2:       rb = $urandom;
          default: rb = '1;
        endcase
        step(rs, ra, rf, rb);
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          s, a, f;
    logic [31:0] b;
    bit          busy, done;
    int          words, errw, errb, lock;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b0; start = 0; aligned = 0; errorFlag = 0; errorBits = '0;
    prev_done = 0;
    model_reset();
    #1;
    chk("reset_state", 64'(state_o), 64'(ST_IDLE));
    chk("reset_busy", 64'(busy), 64'(0));
    cmp_model();
    step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    reset = 1'b1;

    tbl[0] = '{1, 0, 0, 32'h0000_0000, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 32'h0000_0000, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 32'h0000_00FF, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 32'h0000_0000, 1, 0, 1, 1, 0, 0};
    tbl[4] = '{0, 1, 0, 32'h0000_0005, 1, 0, 2, 1, 2, 0};
    tbl[5] = '{0, 0, 1, 32'h0000_00FF, 1, 0, 2, 1, 2, 1};
    tbl[6] = '{0, 0, 0, 32'h0000_0000, 1, 0, 2, 1, 2, 1};
    tbl[7] = '{0, 1, 0, 32'h0000_0000, 1, 0, 2, 1, 2, 1};
    tbl[8] = '{1, 1, 1, 32'h8000_0001, 1, 0, 3, 2, 4, 1};
    tbl[9] = '{0, 1, 0, 32'h0000_0000, 1, 0, 4, 2, 4, 1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].f, tbl[i].b);
      chk("tbl_busy", 64'(busy), 64'(tbl[i].busy));
      chk("tbl_done", 64'(done), 64'(tbl[i].done));
      chk("tbl_words", 64'(wordCount), 64'(tbl[i].words));
      chk("tbl_errw", 64'(errWordCount), 64'(tbl[i].errw));
      chk("tbl_errb", 64'(errBitCount), 64'(BIT_EN ? tbl[i].errb : 0));
      chk("tbl_lock", 64'(lockLoss), 64'(tbl[i].lock));
    end

    // Clean run.
    async_reset();
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    words(15, 0, '0);
    chk("clean_not_done", 64'(done), 64'(0));
    words(1, 0, '0);
    chk("clean_done", 64'(done), 64'(1));
    chk("clean_words", 64'(wordCount), 64'(16));
    chk("clean_errw", 64'(errWordCount), 64'(0));
    chk("clean_errb", 64'(errBitCount), 64'(0));
    chk("clean_lock", 64'(lockLoss), 64'(0));
    words(2, 1, '1);
    chk("done_hold_words", 64'(wordCount), 64'(16));

    // Error run, restarted from DONE.
    step(1, 1, 1, '1);
    chk("restart_words", 64'(wordCount), 64'(0));
    chk("restart_busy", 64'(busy), 64'(1));
    chk("restart_done", 64'(done), 64'(0));
    step(0, 1, 0, '0);
    words(2, 0, '0);
    words(1, 1, 32'h0000_0005);
    words(3, 0, '0);
    words(1, 1, 32'hFFFF_FFFF);
    words(9, 0, '0);
    chk("err_done", 64'(done), 64'(1));
    chk("err_errw", 64'(errWordCount), 64'(2));
    chk("err_errb", 64'(errBitCount), 64'(BIT_EN ? 34 : 0));

    // Lock loss for 5 cycles after word 8, plus a start ignored mid-measure.
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    words(8, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, '0);
      chk("gap_lock", 64'(lockLoss), 64'(1));
      chk("gap_busy", 64'(busy), 64'(1));
      chk("gap_words", 64'(wordCount), 64'(8));
    end
    step(0, 1, 0, '0);
    chk("relock_words", 64'(wordCount), 64'(8));
    words(3, 0, '0);
    step(1, 1, 0, '0);
    chk("ignored_start", 64'(wordCount), 64'(12));
    words(3, 0, '0);
    chk("gap_not_done", 64'(done), 64'(0));
    words(1, 0, '0);
    chk("gap_done", 64'(done), 64'(1));
    chk("gap_final_words", 64'(wordCount), 64'(16));
    chk("gap_final_lock", 64'(lockLoss), 64'(1));

    // Reset mid-run after 10 words.
    step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    words(10, 1, 32'h3);
    chk("mid_words", 64'(wordCount), 64'(10));
    async_reset();
    words(3, 1, '1);
    chk("post_rst_idle", 64'(state_o), 64'(ST_IDLE));
    chk("post_rst_words", 64'(wordCount), 64'(0));
    step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    words(1, 1, 32'h1);
    chk("resume_words", 64'(wordCount), 64'(1));

    // Saturation of the 5-bit instance.
    async_reset();
    step(1, 1, 1, '1);
    step(0, 1, 1, '1);
    words(16, 1, 32'hFFFF_FFFF);
    chk("sat_errb", 64'(s_errBitCount), 64'(BIT_EN ? 31 : 0));
    chk("sat_errw", 64'(s_errWordCount), 64'(16));
    chk("sat_done", 64'(s_done), 64'(1));
    chk("wide_errb", 64'(errBitCount), 64'(BIT_EN ? 512 : 0));
    words(3, 1, 32'hFFFF_FFFF);
    chk("sat_errb_hold", 64'(s_errBitCount), 64'(BIT_EN ? 31 : 0));

    random_phase(3000);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_monitor.md
BER_MONITOR -- requirements
Module: ber_monitor

Interface
REQ-001 Parameter WINDOW_LOG2, default 20: the measurement window is 2^WINDOW_LOG2 aligned words.
REQ-002 Parameter CNT_W, default 32: width of every statistics counter; CNT_W SHALL be greater than WINDOW_LOG2.
REQ-003 clk  input  1  receive user clock, the same clock that drives the upstream aligner.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that requests a new measurement.
REQ-006 aligned  input  1  aligner lock indication.
REQ-007 errorFlag  input  1  asserted when the current word contains at least one bit error.
REQ-008 errorBits  input  32  per-bit error mask of the current word.
REQ-009 busy  output  1  asserted in the WAIT_ALIGN and MEASURE states.
REQ-010 done  output  1  level signal; the counters hold final results while it is asserted.
REQ-011 wordCount  output  CNT_W  number of aligned words counted.
REQ-012 errWordCount  output  CNT_W  number of words with errorFlag asserted.
REQ-013 errBitCount  output  CNT_W  total number of set errorBits.
REQ-014 lockLoss  output  8  number of aligned 1->0 transitions during MEASURE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WAIT_ALIGN, MEASURE, DONE.
REQ-016 start sampled in IDLE or DONE SHALL clear all counters and done, and move the FSM to WAIT_ALIGN on the same edge.
REQ-017 start sampled in WAIT_ALIGN or MEASURE SHALL be ignored; the measurement in progress is not restarted.
REQ-018 WAIT_ALIGN SHALL move to MEASURE on the first edge at which aligned=1; no word is counted on that edge.
REQ-019 In MEASURE, each edge with aligned=1 SHALL increment wordCount by 1, increment errWordCount by errorFlag, and add popcount(errorBits) (0..32) to errBitCount.
REQ-020 Each count update SHALL be visible on the outputs 1 cycle after the input is sampled; there is no further pipeline latency.
REQ-021 aligned=0 sampled in MEASURE SHALL:
- leave the three statistics counters unchanged;
- increment lockLoss, saturating at 255;
- return the FSM to WAIT_ALIGN.
REQ-022 When the edge that counts a word makes wordCount reach 2^WINDOW_LOG2, the FSM SHALL move to DONE and done SHALL read 1 from that cycle until the next accepted start.
REQ-023 Every counter SHALL saturate at all-ones and never wrap; errBitCount SHALL clamp when the addition would overflow.
REQ-024 errorFlag=1 with errorBits=0 SHALL count one error word and zero error bits; errorFlag and errorBits are counted independently.
REQ-025 In IDLE and DONE, the counters SHALL hold their values regardless of aligned, errorFlag and errorBits.

Reset
REQ-026 Asserting reset (low) SHALL force, asynchronously:
- state IDLE;
- busy=0 and done=0;
- all counters and lockLoss to 0.
REQ-027 Reset asserted mid-measurement SHALL discard all partial results; deassertion SHALL leave the block in IDLE until the next start.

Configuration
REQ-028 Macro BER_BIT_ERR_COUNT_EN, when defined, SHALL compile in the popcount adder, and errBitCount SHALL behave as specified above.
REQ-029 Without BER_BIT_ERR_COUNT_EN, errBitCount SHALL be tied to 0, and errorBits SHALL be ignored and carry no logic.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, the lockLoss width (8), and the word width constant (32).
REQ-031 A single sub-module, popcount32, SHALL compute a 6-bit count of a 32-bit input combinationally; it SHALL be instantiated only under BER_BIT_ERR_COUNT_EN.

Verification
REQ-032 The bench SHALL run with WINDOW_LOG2=4 and BER_BIT_ERR_COUNT_EN defined unless a scenario states otherwise.
REQ-033 Clean run: start, aligned=1, 16 clean words -> done=1, wordCount=16, errWordCount=0, errBitCount=0, lockLoss=0.
REQ-034 Error run: words 3 and 7 carry errorBits=32'h0000_0005 (errorFlag=1) and 32'hFFFF_FFFF (errorFlag=1) -> errWordCount=2, errBitCount=34.
REQ-035 Lock loss: aligned=0 for 5 cycles after word 8 -> lockLoss=1, busy=1 throughout, wordCount=8 during the gap, done after 16 aligned words.
REQ-036 Restart and ignore: start during MEASURE -> no effect; start in DONE -> counters read 0 on the next cycle and busy=1.
REQ-037 Reset mid-run: reset low after 10 words -> all outputs 0 immediately and the FSM in IDLE; counting resumes only after start.
REQ-038 Saturation: CNT_W=5, WINDOW_LOG2=4, all words errorBits=32'hFFFF_FFFF -> errBitCount=31 held, no wrap.
